// File: rtl/matgen_sched_pkg.sv
// ---------------------------------------------------------------------------
// matgen_sched_pkg: shared types and constants for matrix-A generation. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package matgen_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABSORB  = 3'd1,
    ST_WAIT_KC = 3'd2,
    ST_FEED    = 3'd3,
    ST_SQUEEZE = 3'd4,
    ST_CLEAR   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam int RATE_LANES_SHAKE128 = 21;
  localparam int RATE_LANES_SHAKE256 = 17;

  localparam logic C_NONCE_ORDER_JI = 1'b0;  // byte0 = j, byte1 = i
  localparam logic C_NONCE_ORDER_IJ = 1'b1;  // byte0 = i, byte1 = j

  function automatic logic [15:0] pack_nonce(input logic [1:0] i, input logic [1:0] j,
                                             input logic order);
    if (order == C_NONCE_ORDER_IJ) return {6'b0, j, 6'b0, i};
    else                           return {6'b0, i, 6'b0, j};
  endfunction

endpackage

`default_nettype wire

// File: rtl/matgen_idx_cnt.sv
// ---------------------------------------------------------------------------
// matgen_idx_cnt: (i,j) polynomial index counter, row-major with last flag. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module matgen_idx_cnt
  import matgen_sched_pkg::*;
#(
  parameter int K = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_adv,
  output logic [1:0] o_i,
  output logic [1:0] o_j,
  output logic       o_last
);

  logic [1:0] r_i;
  logic [1:0] r_j;
  logic       w_j_wrap;

  assign w_j_wrap = (r_j == 2'(K - 1));
  assign o_last   = w_j_wrap && (r_i == 2'(K - 1));

  // The last advance wraps back to (0,0) so the nonce idles at zero.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_adv) begin
      if (w_j_wrap) begin
        r_j <= '0;
        r_i <= o_last ? 2'd0 : r_i + 2'd1;
      end else begin
        r_j <= r_j + 2'd1;
      end
    end
  end

  assign o_i = r_i;
  assign o_j = r_j;

endmodule

`default_nettype wire

// File: rtl/matgen_sched.sv
// ---------------------------------------------------------------------------
// matgen_sched: sequences Keccak absorb/squeeze and Parse feeding per (i,j). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module matgen_sched
  import matgen_sched_pkg::*;
#(
  parameter int K          = 3,
  parameter int RATE_LANES = RATE_LANES_SHAKE128,
  parameter int TRANSPOSE  = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        kc_start,
  output logic [15:0] kc_nonce,
  output logic        kc_squeeze,
  input  logic        kc_done,
  output logic [4:0]  kc_lane_idx,
  input  logic [63:0] kc_lane,
  output logic [63:0] prs_in,
  output logic        prs_valid,
  input  logic        prs_gimme,
  input  logic        prs_done,
  output logic        prs_clr,
  output logic [1:0]  poly_i,
  output logic [1:0]  poly_j,
  output logic        poly_done
);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_lane_idx;
  logic [63:0] r_prs_hold;
  logic        w_xfer;
  logic        w_cnt_clr;
  logic        w_adv;
  logic        w_last;

  matgen_idx_cnt #(.K(K)) u_idx_cnt (
    .clk    (clk),
    .rst    (resetb),
    .i_clr  (w_cnt_clr),
    .i_adv  (w_adv),
    .o_i    (poly_i),
    .o_j    (poly_j),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (resetb) begin
      r_state    <= ST_IDLE;
      r_lane_idx <= '0;
      r_prs_hold <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_WAIT_KC && kc_done) r_lane_idx <= '0;
      else if (w_xfer)                      r_lane_idx <= r_lane_idx + 5'd1;
      if (w_xfer) r_prs_hold <= kc_lane;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_xfer     = 1'b0;
    w_cnt_clr  = 1'b0;
    w_adv      = 1'b0;
    kc_start   = 1'b0;
    kc_squeeze = 1'b0;
    prs_clr    = 1'b0;
    poly_done  = 1'b0;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_ABSORB;
        end
      end
      ST_ABSORB: begin
        kc_start = 1'b1;
        w_next   = ST_WAIT_KC;
      end
      ST_WAIT_KC: begin
        if (kc_done) w_next = ST_FEED;
      end
      ST_FEED: begin
        // Parse completion outranks an exhausted block: no pointless squeeze.
        if (prs_done)                            w_next = ST_CLEAR;
        else if (r_lane_idx == 5'(RATE_LANES))   w_next = ST_SQUEEZE;
        else if (prs_gimme)                      w_xfer = 1'b1;
      end
      ST_SQUEEZE: begin
        kc_squeeze = 1'b1;
        w_next     = ST_WAIT_KC;
      end
      ST_CLEAR: begin
        poly_done = 1'b1;
        prs_clr   = 1'b1;
        w_adv     = 1'b1;
        w_next    = w_last ? ST_DONE : ST_ABSORB;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign prs_valid   = w_xfer;
  assign prs_in      = w_xfer ? kc_lane : r_prs_hold;
  assign kc_lane_idx = (r_state == ST_FEED) ? r_lane_idx : 5'd0;
  assign kc_nonce    = pack_nonce(poly_i, poly_j,
                                  (TRANSPOSE != 0) ? C_NONCE_ORDER_IJ : C_NONCE_ORDER_JI);

endmodule

`default_nettype wire

// File: tb/tb_matgen_sched.sv
// ---------------------------------------------------------------------------
// tb_matgen_sched: scoreboard bench with Keccak and Parse behavioural models. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_matgen_sched;

  localparam int C_K  = 2;
  localparam int C_RL = 21;

  localparam logic [2:0] EV_START = 3'd1;
  localparam logic [2:0] EV_WORD  = 3'd2;
  localparam logic [2:0] EV_SQZ   = 3'd3;
  localparam logic [2:0] EV_PD    = 3'd4;
  localparam logic [2:0] EV_DONE  = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        resetb;
  logic        start;
  logic        busy, done, kc_start, kc_squeeze, kc_done;
  logic [15:0] kc_nonce;
  logic [4:0]  kc_lane_idx;
  logic [63:0] kc_lane, prs_in;
  logic        prs_valid, prs_gimme, prs_done, prs_clr;
  logic [1:0]  poly_i, poly_j;
  logic        poly_done;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   pd_cnt   = 0;
  bit   mon_en   = 1'b0;
  bit   gimme_tog = 1'b0;
  logic spur_done = 1'b0;
  int   prs_limit = 30;

  // Keccak model: kc_done three cycles after start/squeeze; lanes tagged with nonce/block/lane.
  logic [2:0] r_kc_pipe;
  logic [7:0] r_blk;
  // Parse model: counts accepted words, level done once the limit is reached.
  int         r_acc;

  always @(posedge clk) begin
    if (resetb) begin
      r_kc_pipe <= '0;
      r_blk     <= '0;
      r_acc     <= 0;
    end else begin
      r_kc_pipe <= {r_kc_pipe[1:0], kc_start | kc_squeeze};
      if (kc_start)        r_blk <= '0;
      else if (kc_squeeze) r_blk <= r_blk + 8'd1;
      if (prs_clr)                     r_acc <= 0;
      else if (prs_valid && prs_gimme) r_acc <= r_acc + 1;
    end
  end

  assign kc_done  = r_kc_pipe[2] | spur_done;
  assign kc_lane  = {8'hC3, r_blk, kc_nonce, 16'h0000, 11'h000, kc_lane_idx};
  assign prs_done = (r_acc >= prs_limit);

  matgen_sched #(.K(C_K), .RATE_LANES(C_RL), .TRANSPOSE(0)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .kc_start    (kc_start),
    .kc_nonce    (kc_nonce),
    .kc_squeeze  (kc_squeeze),
    .kc_done     (kc_done),
    .kc_lane_idx (kc_lane_idx),
    .kc_lane     (kc_lane),
    .prs_in      (prs_in),
    .prs_valid   (prs_valid),
    .prs_gimme   (prs_gimme),
    .prs_done    (prs_done),
    .prs_clr     (prs_clr),
    .poly_i      (poly_i),
    .poly_j      (poly_j),
    .poly_done   (poly_done)
  );

  always #5 clk = ~clk;

  initial begin
    prs_gimme = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      prs_gimme = gimme_tog ? ~prs_gimme : 1'b1;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_ev(input string name, input logic [2:0] kind, input logic [63:0] data);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event kind %0d data %0h, none expected", name, kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.data !== data) begin
        n_fail++;
        $display("FAIL %s: got kind %0d data %0h expected kind %0d data %0h at %0t",
                 name, kind, data, e.kind, e.data, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prs_valid) check("valid_needs_gimme", {127'b0, prs_gimme}, 128'd1);
      if (prs_done)  check("valid_low_on_prs_done", {127'b0, prs_valid}, 128'd0);
      if (kc_start) chk_ev("kc_start", EV_START, {48'h0, kc_nonce});
      if (prs_valid) chk_ev("word", EV_WORD, prs_in);
      if (kc_squeeze) chk_ev("kc_squeeze", EV_SQZ, 64'h0);
      if (poly_done) begin
        chk_ev("poly_done", EV_PD, {60'h0, poly_i, poly_j});
        check("prs_clr_with_poly_done", {127'b0, prs_clr}, 128'd1);
        pd_cnt++;
      end
      if (done) begin
        chk_ev("done", EV_DONE, 64'h0);
        check("busy_low_at_done", {127'b0, busy}, 128'd0);
        done_cnt++;
      end
    end
  end

  // Expected stream: per (i,j) one kc_start, L words in lane order, a squeeze after
  // every full block still needed, then poly_done; one done at the end.
  task automatic build_expected(input int L);
    logic [15:0] nonce;
    logic [1:0]  pi, pj;
    ev_t         e;
    for (int p = 0; p < C_K * C_K; p++) begin
      pi    = 2'(p / C_K);
      pj    = 2'(p % C_K);
      nonce = {6'b0, pi, 6'b0, pj};
      e.kind = EV_START; e.data = {48'h0, nonce}; exp_q.push_back(e);
      for (int w = 0; w < L; w++) begin
        e.kind = EV_WORD;
        e.data = {8'hC3, 8'(w / C_RL), nonce, 16'h0000, 16'(w % C_RL)};
        exp_q.push_back(e);
        if ((w % C_RL) == C_RL - 1 && w + 1 < L) begin
          e.kind = EV_SQZ; e.data = 64'h0; exp_q.push_back(e);
        end
      end
      e.kind = EV_PD; e.data = {60'h0, pi, pj}; exp_q.push_back(e);
    end
    e.kind = EV_DONE; e.data = 64'h0; exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    repeat (3) @(negedge clk);
    resetb = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    @(negedge clk);
    while (!prs_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout waiting for prs_valid, got 0 expected 1", name);
    end
  endtask

  task automatic run_matrix(input string name, input int L, input bit tog, input bit disturb);
    int d0 = done_cnt;
    int t  = 0;
    exp_q.delete();
    build_expected(L);
    prs_limit = L;
    gimme_tog = tog;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, {127'b0, busy}, 128'd1);
    if (disturb) begin
      wait_valid(name);
      spur_done = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      start     = 1'b0;
    end
    while (done_cnt == d0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout waiting for done, got 0 expected 1", name);
      apply_reset();
    end
    @(negedge clk);
    check({name, "_busy_idle"}, {127'b0, busy}, 128'd0);
    check({name, "_queue_drained"}, 128'(exp_q.size()), 128'd0);
    gimme_tog = 1'b0;
  endtask

  initial begin
    int t;
    resetb = 1'b1;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {32'b0, busy, done, kc_start, kc_nonce, kc_squeeze, kc_lane_idx, prs_in,
           prs_valid, prs_clr, poly_i, poly_j, poly_done}, 128'd0);
    resetb = 1'b0;
    mon_en = 1'b1;

    run_matrix("basic30", 30, 1'b0, 1'b0);
    run_matrix("toggle30", 30, 1'b1, 1'b0);
    run_matrix("early6", 6, 1'b0, 1'b0);
    run_matrix("three_sqz", 70, 1'b0, 1'b0);
    run_matrix("disturb30", 30, 1'b0, 1'b1);

    // Abort in FEED of polynomial (0,1), then a clean restart from nonce 0x0000.
    exp_q.delete();
    build_expected(30);
    prs_limit = 30;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (pd_cnt == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    pd_cnt = 0;
    wait_valid("midreset");
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    resetb = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_outputs",
          {32'b0, busy, done, kc_start, kc_nonce, kc_squeeze, kc_lane_idx, prs_in,
           prs_valid, prs_clr, poly_i, poly_j, poly_done}, 128'd0);
    @(negedge clk);
    resetb = 1'b0;
    check("midreset_no_done", 128'(done_cnt), 128'd5);
    mon_en = 1'b1;
    run_matrix("restart30", 30, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
